// File: rtl/rv_mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
// Requester IDs and the address-width helper.
package rv_mem_arb_pkg;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin arbiter for the shared read port.
// The last winner loses the next tie; it moves only on advance.
module rv_rr_arb2
  import rv_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == REQ_M1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (advance && (gnt != 2'b00))
      last_d = gnt[1] ? REQ_M1 : REQ_M0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_M1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Fetch/data arbiter for a dual-port RAM: m1 writes own port A,
// m0/m1 reads share port B with registered, write-bypassed responses.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = clog2(DEPTH),
  localparam int NB    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic [AW-1:0]    m0_addr,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic [NB-1:0]    m1_strobe,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             ram_wena,
  output logic [NB-1:0]    ram_strobe,
  output logic [AW-1:0]    ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_renb,
  output logic [AW-1:0]    ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb
);

  logic             m1_wr;
  logic [1:0]       rd_req;
  logic [1:0]       rd_gnt;
  logic [WIDTH-1:0] rd_data;

  logic             m0_rvalid_q, m1_rvalid_q;
  logic [WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  assign m1_wr  = m1_req & m1_we & ~rst;
  assign rd_req = rst ? 2'b00 : {m1_req & ~m1_we, m0_req};

  rv_rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (ram_renb),
    .gnt     (rd_gnt)
  );

  assign m0_gnt = rd_gnt[0];
  assign m1_gnt = rd_gnt[1] | m1_wr;

  assign ram_wena   = m1_wr;
  assign ram_strobe = m1_wr ? m1_strobe : '0;
  assign ram_addra  = m1_wr ? m1_addr   : '0;
  assign ram_dina   = m1_wr ? m1_wdata  : '0;
  assign ram_renb   = |rd_gnt;

  always_comb begin
    ram_addrb = '0;
    if (rd_gnt[0])      ram_addrb = m0_addr;
    else if (rd_gnt[1]) ram_addrb = m1_addr;
  end

  // Same-address write this cycle: forward the written bytes.
  always_comb begin
    rd_data = ram_doutb;
    if (ram_wena && ram_renb && (ram_addra == ram_addrb)) begin
      for (int b = 0; b < NB; b++)
        if (ram_strobe[b]) rd_data[8*b +: 8] = ram_dina[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= rd_gnt[0];
      m1_rvalid_q <= rd_gnt[1];
      if (rd_gnt[0]) m0_rdata_q <= rd_data;
      if (rd_gnt[1]) m1_rdata_q <= rd_data;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb with a behavioural dual-port RAM.
// Untouched words read as 0x10000000 + addr, except addr 5 and 7.
module tb_rv_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [9:0]  m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [9:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_strobe;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        ram_wena;
  logic [3:0]  ram_strobe;
  logic [9:0]  ram_addra;
  logic [31:0] ram_dina;
  logic        ram_renb;
  logic [9:0]  ram_addrb;
  logic [31:0] ram_doutb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_mem_arb dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_strobe  (m1_strobe),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .ram_wena   (ram_wena),
    .ram_strobe (ram_strobe),
    .ram_addra  (ram_addra),
    .ram_dina   (ram_dina),
    .ram_renb   (ram_renb),
    .ram_addrb  (ram_addrb),
    .ram_doutb  (ram_doutb)
  );

  bit [31:0] mem [1024];
  bit        wv  [1024];

  function automatic logic [31:0] init_val(input logic [9:0] a);
    if (a == 10'd5) return 32'hDEADBEEF;
    if (a == 10'd7) return 32'hAABBCCDD;
    return 32'h1000_0000 + {22'd0, a};
  endfunction

  function automatic logic [31:0] rd_word(input logic [9:0] a);
    return wv[a] ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  assign ram_doutb = rd_word(ram_addrb);

  always @(posedge clk) begin
    if (ram_wena) begin
      mem[ram_addra] <= merge(rd_word(ram_addra), ram_dina, ram_strobe);
      wv[ram_addra]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
    m1_we  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 10'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd2;
    m1_wdata = '0; m1_strobe = '0;
    tick();
    tick();
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_renb", ram_renb, 0);
    chk("rst_wena", ram_wena, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    rst = 1'b0;
    idle();
    tick();

    // single m0 read of addr 5
    m0_req = 1'b1; m0_addr = 10'd5;
    #1;
    chk("rd5_m0_gnt", m0_gnt, 1);
    chk("rd5_m1_gnt", m1_gnt, 0);
    chk("rd5_addrb", ram_addrb, 5);
    tick();
    idle();
    chk("rd5_rvalid", m0_rvalid, 1);
    chk("rd5_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd5_m1_rvalid", m1_rvalid, 0);
    tick();
    chk("rd5_pulse", m0_rvalid, 0);
    chk("rd5_hold", m0_rdata, 32'hDEADBEEF);

    // single m1 read of addr 9
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd9;
    #1;
    chk("rd9_m1_gnt", m1_gnt, 1);
    chk("rd9_m0_gnt", m0_gnt, 0);
    tick();
    idle();
    chk("rd9_rvalid", m1_rvalid, 1);
    chk("rd9_rdata", m1_rdata, 32'h1000_0009);

    // contention: m0 addr 10, m1 addr 11
    m0_req = 1'b1; m0_addr = 10'd10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_m0_gnt", i), m0_gnt, 32'((i % 2) == 0));
      chk($sformatf("rr%0d_m1_gnt", i), m1_gnt, 32'((i % 2) == 1));
      if (i > 0) begin
        chk($sformatf("rr%0d_m0_rv", i), m0_rvalid, 32'((i % 2) == 1));
        chk($sformatf("rr%0d_m1_rv", i), m1_rvalid, 32'((i % 2) == 0));
      end
      tick();
    end
    idle();
    chk("rr_end_m1_rv", m1_rvalid, 1);
    chk("rr_end_m0_rv", m0_rvalid, 0);
    chk("rr_m0_rdata", m0_rdata, 32'h1000_000A);
    chk("rr_m1_rdata", m1_rdata, 32'h1000_000B);

    // write/read hazard on addr 7
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd7;
    m1_wdata = 32'h11223344; m1_strobe = 4'b0101;
    m0_req = 1'b1; m0_addr = 10'd7;
    #1;
    chk("hz_m0_gnt", m0_gnt, 1);
    chk("hz_m1_gnt", m1_gnt, 1);
    chk("hz_wena", ram_wena, 1);
    chk("hz_addra", ram_addra, 7);
    chk("hz_strobe", ram_strobe, 4'b0101);
    chk("hz_dina", ram_dina, 32'h11223344);
    tick();
    idle();
    chk("hz_m0_rvalid", m0_rvalid, 1);
    chk("hz_m0_rdata", m0_rdata, 32'hAA22CC44);
    chk("hz_m1_rvalid", m1_rvalid, 0);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd7;
    tick();
    idle();
    chk("rd7_rvalid", m1_rvalid, 1);
    chk("rd7_rdata", m1_rdata, 32'hAA22CC44);

    // write addr 3 alongside m0 read of addr 4
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd3;
    m1_wdata = 32'h55667788; m1_strobe = 4'hF;
    m0_req = 1'b1; m0_addr = 10'd4;
    #1;
    chk("wr3_m0_gnt", m0_gnt, 1);
    chk("wr3_m1_gnt", m1_gnt, 1);
    tick();
    idle();
    chk("wr3_m0_rvalid", m0_rvalid, 1);
    chk("wr3_m1_rvalid", m1_rvalid, 0);
    chk("wr3_m0_rdata", m0_rdata, 32'h1000_0004);
    chk("wr3_m1_hold", m1_rdata, 32'hAA22CC44);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd3;
    tick();
    idle();
    chk("rd3_rdata", m1_rdata, 32'h55667788);

    // reset lands on the response edge of an m1 read
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd11;
    #1;
    chk("rsr_m1_gnt", m1_gnt, 1);
    #3;
    rst = 1'b1;
    idle();
    tick();
    chk("rsr_m1_rvalid", m1_rvalid, 0);
    chk("rsr_m1_rdata", m1_rdata, 0);
    chk("rsr_m0_rdata", m0_rdata, 0);
    chk("rsr_m0_rvalid", m0_rvalid, 0);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd20;
    m1_wdata = 32'hFFFFFFFF; m1_strobe = 4'hF;
    #1;
    chk("rsw_m1_gnt", m1_gnt, 0);
    chk("rsw_wena", ram_wena, 0);
    tick();
    rst = 1'b0;
    idle();
    m0_req = 1'b1; m0_addr = 10'd20;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd21;
    #1;
    chk("prs_m0_gnt", m0_gnt, 1);
    chk("prs_m1_gnt", m1_gnt, 0);
    tick();
    m0_req = 1'b0;
    chk("prs_m0_rvalid", m0_rvalid, 1);
    chk("prs_m0_rdata", m0_rdata, 32'h1000_0014);
    #1;
    chk("prs_m1_gnt2", m1_gnt, 1);
    tick();
    idle();
    chk("prs_m1_rdata", m1_rdata, 32'h1000_0015);

    // reset after an m0 win must hand the next tie back to m0
    m0_req = 1'b1; m0_addr = 10'd1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 10'd2;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd3;
    #1;
    chk("rw_m0_gnt", m0_gnt, 1);
    chk("rw_m1_gnt", m1_gnt, 0);
    tick();
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
